// File: rtl/nf_mac_10g_tx_if.sv
// AXI4-Stream beat channel carrying user frames into the 10G MAC transmit path.
interface nf_mac_10g_tx_if;
    logic [63:0] tx_axis_tdata;
    logic [7:0]  tx_axis_tkeep;
    logic        tx_axis_tvalid;
    logic        tx_axis_tlast;
    logic        tx_axis_tuser;
    logic        tx_axis_tready;

    // A beat transfers on a rising edge where tvalid and tready are both 1; the master holds the beat stable until then.
    modport master (output tx_axis_tdata, tx_axis_tkeep, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser,
                    input  tx_axis_tready);
    modport slave  (input  tx_axis_tdata, tx_axis_tkeep, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser,
                    output tx_axis_tready);
endinterface

// File: rtl/nf_mac_10g_tx.sv
// 10G MAC transmit: AXI4-Stream frames to XGMII with preamble, pad, CRC-32 FCS, terminate and IFG.
module nf_mac_10g_tx #(
    parameter int MIN_FRAME = 60,
    parameter int MIN_IFG   = 12
) (
    input  logic                tx_clk0,
    input  logic                reset,
    input  logic                tx_axis_aresetn,
    input  logic                tx_dcm_locked,
    input  logic [79:0]         tx_configuration_vector,
    input  logic [7:0]          tx_ifg_delay,
    nf_mac_10g_tx_if.slave      axis,
    output logic [63:0]         xgmii_txd,
    output logic [7:0]          xgmii_txc,
    output logic [25:0]         tx_statistics_vector,
    output logic                tx_statistics_valid,
    output logic [2:0]          dbg_state_o
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_TAIL, S_DROP, S_IFG} state_t;

    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;
    localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) r = (r >> 1) ^ ((r[0] ^ b[k]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    state_t      state_q;
    logic [63:0] txd_q;
    logic [7:0]  txc_q;
    logic        tready_q;
    logic [31:0] crc_q;
    logic [13:0] len_q;
    logic [2:0]  fidx_q;
    logic        padded_q, bad_q;
    logic [9:0]  ifg_cnt_q;
    logic [25:0] stat_vec_q;
    logic        stat_valid_q, stat_pend_q;

    logic        en, in_tail, bad_now;
    logic [3:0]  nd;
    logic [9:0]  gap;
    logic [10:0] ifg_sum;
    logic [9:0]  ifg_sat;
    logic [14:0] len_fcs;
    logic [13:0] stat_len;
    logic        unused_cfg;

    assign unused_cfg = ^tx_configuration_vector[79:2];
    assign en = tx_axis_aresetn & ~tx_configuration_vector[0] & tx_configuration_vector[1] & tx_dcm_locked;
    assign gap = (tx_ifg_delay > 8'(MIN_IFG)) ? {2'b00, tx_ifg_delay} : 10'(MIN_IFG);
    assign ifg_sum = {1'b0, ifg_cnt_q} + 11'd8;
    assign ifg_sat = ifg_sum[10] ? 10'h3FF : ifg_sum[9:0];

    // Lanes past the last data byte of a word carry the tail stream: pad, FCS, /T/, then /I/.
    always_comb begin
        in_tail = (state_q == S_TAIL) || axis.tx_axis_tlast;
        bad_now = (state_q == S_TAIL) ? bad_q : axis.tx_axis_tuser;
        nd = 4'd8;
        if (state_q == S_TAIL) begin
            nd = 4'd0;
        end else if (axis.tx_axis_tlast) begin
            nd = 4'd0;
            for (int i = 0; i < 8; i++) nd = nd + {3'b000, axis.tx_axis_tkeep[i]};
        end
    end

    logic [63:0] b_txd;
    logic [7:0]  b_txc;
    logic [31:0] b_crc, b_fcs;
    logic [13:0] b_len;
    logic [2:0]  b_fidx;
    logic        b_tdone, b_padded;
    logic [3:0]  b_tlane;

    always_comb begin
        b_txd = '0;
        b_txc = '0;
        b_crc = crc_q;
        b_fcs = '0;
        b_len = len_q;
        b_fidx = fidx_q;
        b_tdone = 1'b0;
        b_padded = padded_q;
        b_tlane = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nd) begin
                b_txd[8*i +: 8] = axis.tx_axis_tdata[8*i +: 8];
                b_crc = crc_byte(b_crc, axis.tx_axis_tdata[8*i +: 8]);
                if (b_len != 14'h3FFF) b_len = b_len + 14'd1;
            end else if (in_tail) begin
                if (b_len < 14'(MIN_FRAME)) begin
                    b_crc = crc_byte(b_crc, 8'h00);
                    b_len = b_len + 14'd1;
                    b_padded = 1'b1;
                end else if (b_fidx < 3'd4) begin
                    b_fcs = ~b_crc;
                    b_txd[8*i +: 8] = b_fcs[{b_fidx[1:0], 3'b000} +: 8];
                    b_fidx = b_fidx + 3'd1;
                end else if (!b_tdone) begin
                    b_txd[8*i +: 8] = 8'hFD;
                    b_txc[i] = 1'b1;
                    b_tdone = 1'b1;
                    b_tlane = 4'(i);
                end else begin
                    b_txd[8*i +: 8] = 8'h07;
                    b_txc[i] = 1'b1;
                end
            end
        end
        len_fcs = {1'b0, b_len} + 15'd4;
        stat_len = len_fcs[14] ? 14'h3FFF : len_fcs[13:0];
    end

    always_ff @(posedge tx_clk0 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            txd_q <= IDLE_W;
            txc_q <= 8'hFF;
            tready_q <= 1'b0;
            crc_q <= 32'hFFFFFFFF;
            len_q <= '0;
            fidx_q <= '0;
            padded_q <= 1'b0;
            bad_q <= 1'b0;
            ifg_cnt_q <= '0;
            stat_vec_q <= '0;
            stat_valid_q <= 1'b0;
            stat_pend_q <= 1'b0;
        end else if (!en) begin
            // Soft reset, datapath reset, disable or lost lock: abort silently to idle.
            state_q <= S_IDLE;
            txd_q <= IDLE_W;
            txc_q <= 8'hFF;
            tready_q <= 1'b0;
            crc_q <= 32'hFFFFFFFF;
            len_q <= '0;
            fidx_q <= '0;
            padded_q <= 1'b0;
            bad_q <= 1'b0;
            ifg_cnt_q <= '0;
            stat_vec_q <= '0;
            stat_valid_q <= 1'b0;
            stat_pend_q <= 1'b0;
        end else begin
            stat_valid_q <= stat_pend_q;
            stat_pend_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    txd_q <= IDLE_W;
                    txc_q <= 8'hFF;
                    tready_q <= 1'b0;
                    if (axis.tx_axis_tvalid) begin
                        state_q <= S_PRE;
                        txd_q <= START_W;
                        txc_q <= 8'h01;
                        tready_q <= 1'b1;
                        crc_q <= 32'hFFFFFFFF;
                        len_q <= '0;
                        fidx_q <= '0;
                        padded_q <= 1'b0;
                        bad_q <= 1'b0;
                    end
                end
                S_PRE, S_DATA, S_TAIL: begin
                    if (state_q != S_TAIL && !axis.tx_axis_tvalid) begin
                        state_q <= S_DROP;
                        txd_q <= ERR_W;
                        txc_q <= 8'hFF;
                        ifg_cnt_q <= 10'd8;
                        stat_vec_q <= {9'd0, 1'b0, len_q, 1'b1, 1'b0};
                        stat_pend_q <= 1'b1;
                    end else begin
                        txd_q <= b_txd;
                        txc_q <= b_txc;
                        crc_q <= b_crc;
                        len_q <= b_len;
                        fidx_q <= b_fidx;
                        padded_q <= b_padded;
                        if (state_q != S_TAIL) state_q <= S_DATA;
                        if (in_tail) begin
                            tready_q <= 1'b0;
                            bad_q <= bad_now;
                            if (b_tdone) begin
                                state_q <= S_IFG;
                                stat_pend_q <= 1'b1;
                                stat_vec_q <= {9'd0, b_padded, stat_len, bad_now, ~bad_now};
                                if (bad_now) begin
                                    txd_q <= ERR_W;
                                    txc_q <= 8'hFF;
                                    ifg_cnt_q <= 10'd8;
                                end else begin
                                    ifg_cnt_q <= 10'd8 - {6'd0, b_tlane};
                                end
                            end else begin
                                state_q <= S_TAIL;
                            end
                        end
                    end
                end
                S_DROP: begin
                    txd_q <= IDLE_W;
                    txc_q <= 8'hFF;
                    ifg_cnt_q <= ifg_sat;
                    if (axis.tx_axis_tvalid && axis.tx_axis_tlast) begin
                        state_q <= S_IFG;
                        tready_q <= 1'b0;
                    end
                end
                S_IFG: begin
                    // The idle word emitted on this edge counts toward the gap.
                    txd_q <= IDLE_W;
                    txc_q <= 8'hFF;
                    tready_q <= 1'b0;
                    ifg_cnt_q <= ifg_sat;
                    if (ifg_sum >= {1'b0, gap}) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q <= IDLE_W;
                    txc_q <= 8'hFF;
                    tready_q <= 1'b0;
                end
            endcase
        end
    end

    assign axis.tx_axis_tready  = tready_q;
    assign xgmii_txd            = txd_q;
    assign xgmii_txc            = txc_q;
    assign tx_statistics_vector = stat_vec_q;
    assign tx_statistics_valid  = stat_valid_q;
    assign dbg_state_o          = state_q;
endmodule

// File: tb/tb_nf_mac_10g_tx.sv
// Directed bench for nf_mac_10g_tx: byte-stream reference frames feed a word/statistics scoreboard.
module tb_nf_mac_10g_tx;
    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;
    localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;

    logic        tx_clk0 = 1'b0;
    logic        reset;
    logic        tx_axis_aresetn;
    logic        tx_dcm_locked;
    logic [79:0] tx_configuration_vector;
    logic [7:0]  tx_ifg_delay;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [25:0] tx_statistics_vector;
    logic        tx_statistics_valid;
    logic [2:0]  dbg_state;

    nf_mac_10g_tx_if axis_if();

    nf_mac_10g_tx #(.MIN_FRAME(60), .MIN_IFG(12)) dut (
        .tx_clk0(tx_clk0),
        .reset(reset),
        .tx_axis_aresetn(tx_axis_aresetn),
        .tx_dcm_locked(tx_dcm_locked),
        .tx_configuration_vector(tx_configuration_vector),
        .tx_ifg_delay(tx_ifg_delay),
        .axis(axis_if),
        .xgmii_txd(xgmii_txd),
        .xgmii_txc(xgmii_txc),
        .tx_statistics_vector(tx_statistics_vector),
        .tx_statistics_valid(tx_statistics_valid),
        .dbg_state_o(dbg_state)
    );

    // clock and watchdog
    always #5 tx_clk0 = ~tx_clk0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [71:0] exp_q[$];
    logic [25:0] exp_stat_q[$];
    int          total = 0;
    int          bad = 0;
    logic [7:0]  fr [0:127];
    bit          in_frame = 0;
    bit          have_prev = 0;
    int          gap_cnt = 0;

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    // reference model: builds the expected XGMII words and statistics of one frame
    task automatic expect_frame(input int n, input logic tuser);
        logic [7:0]  s[$];
        bit          c[$];
        logic [31:0] crc;
        logic [63:0] d;
        logic [7:0]  k;
        logic        padded;
        int          len;
        int          nw;
        for (int i = 0; i < n; i++) begin s.push_back(fr[i]); c.push_back(1'b0); end
        padded = (n < 60);
        while (s.size() < 60) begin s.push_back(8'h00); c.push_back(1'b0); end
        crc = 32'hFFFFFFFF;
        foreach (s[i]) begin
            for (int b = 0; b < 8; b++) crc = (crc >> 1) ^ ((crc[0] ^ s[i][b]) ? 32'hEDB88320 : 32'h0);
        end
        crc = ~crc;
        len = s.size() + 4;
        for (int i = 0; i < 4; i++) begin s.push_back(crc[8*i +: 8]); c.push_back(1'b0); end
        s.push_back(8'hFD); c.push_back(1'b1);
        while (s.size() % 8 != 0) begin s.push_back(8'h07); c.push_back(1'b1); end
        exp_q.push_back({8'h01, START_W});
        nw = s.size() / 8;
        for (int w = 0; w < nw; w++) begin
            for (int i = 0; i < 8; i++) begin d[8*i +: 8] = s[8*w + i]; k[i] = c[8*w + i]; end
            if (tuser && w == nw - 1) exp_q.push_back({8'hFF, ERR_W});
            else exp_q.push_back({k, d});
        end
        exp_stat_q.push_back({9'd0, padded, 14'(len), tuser, ~tuser});
    endtask

    task automatic expect_underrun(input int nbeats);
        logic [63:0] d;
        exp_q.push_back({8'h01, START_W});
        for (int w = 0; w < nbeats; w++) begin
            for (int i = 0; i < 8; i++) d[8*i +: 8] = fr[8*w + i];
            exp_q.push_back({8'h00, d});
        end
        exp_q.push_back({8'hFF, ERR_W});
        exp_stat_q.push_back({9'd0, 1'b0, 14'(8 * nbeats), 1'b1, 1'b0});
    endtask

    // driver tasks
    task automatic put_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        int w;
        axis_if.tx_axis_tdata  = d;
        axis_if.tx_axis_tkeep  = k;
        axis_if.tx_axis_tlast  = l;
        axis_if.tx_axis_tuser  = u;
        axis_if.tx_axis_tvalid = 1'b1;
        w = 0;
        @(negedge tx_clk0);
        while (!axis_if.tx_axis_tready && w < 300) begin @(negedge tx_clk0); w++; end
        if (w >= 300) begin
            total++;
            bad++;
            $display("FAIL tready_timeout: got=no tready in %0d cycles expected=tready", w);
        end
        @(posedge tx_clk0);
        #1;
    endtask

    task automatic send_frame(input int n, input logic tuser, input int stall_at);
        logic [63:0] d;
        logic [7:0]  k;
        int          nb;
        int          rem;
        nb = (n + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            if (b == stall_at) begin
                axis_if.tx_axis_tvalid = 1'b0;
                @(posedge tx_clk0);
                #1;
            end
            for (int i = 0; i < 8; i++) d[8*i +: 8] = (8*b + i < n) ? fr[8*b + i] : 8'h00;
            rem = n - 8*b;
            k = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
            put_beat(d, k, b == nb - 1, (b == nb - 1) ? tuser : 1'b0);
        end
        axis_if.tx_axis_tvalid = 1'b0;
        axis_if.tx_axis_tlast  = 1'b0;
        axis_if.tx_axis_tuser  = 1'b0;
    endtask

    task automatic fill_frame(input int n, input int seed);
        for (int i = 0; i < n; i++) fr[i] = 8'(i * 37 + seed);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || exp_stat_q.size() != 0) && w < 3000) begin
            @(negedge tx_clk0);
            w++;
        end
        if (w >= 3000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: words_left=%0d stats_left=%0d expected=0", exp_q.size(), exp_stat_q.size());
        end
        repeat (4) @(negedge tx_clk0);
    endtask

    // monitor / scoreboard
    always @(negedge tx_clk0) begin
        int need;
        if (!reset) begin
            need = (tx_ifg_delay > 8'd12) ? int'(tx_ifg_delay) : 12;
            if (!in_frame && xgmii_txc == 8'hFF && xgmii_txd == IDLE_W) begin
                gap_cnt += 8;
            end else begin
                if (!in_frame) begin
                    in_frame = 1;
                    if (have_prev) begin
                        total++;
                        if (gap_cnt < need) begin
                            bad++;
                            $display("FAIL ifg_gap: got=%0d bytes expected>=%0d", gap_cnt, need);
                        end
                    end
                end
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got=%h_%h expected=idle", xgmii_txc, xgmii_txd);
                end else begin
                    check("xgmii_word", {xgmii_txc, xgmii_txd}, exp_q.pop_front());
                end
                if (xgmii_txc == 8'hFF && xgmii_txd == ERR_W) begin
                    in_frame = 0;
                    have_prev = 1;
                    gap_cnt = 8;
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        if (in_frame && xgmii_txc[i] && xgmii_txd[8*i +: 8] == 8'hFD) begin
                            in_frame = 0;
                            have_prev = 1;
                            gap_cnt = 8 - i;
                        end
                    end
                end
            end
            if (tx_statistics_valid) begin
                if (exp_stat_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_stats: got=%h expected=no strobe", tx_statistics_vector);
                end else begin
                    check("stats", {46'd0, tx_statistics_vector}, {46'd0, exp_stat_q.pop_front()});
                end
            end
        end
    end

    // main sequence
    initial begin
        reset = 1'b1;
        tx_axis_aresetn = 1'b0;
        tx_dcm_locked = 1'b0;
        tx_configuration_vector = 80'h23;
        tx_ifg_delay = 8'd0;
        axis_if.tx_axis_tdata  = '0;
        axis_if.tx_axis_tkeep  = '0;
        axis_if.tx_axis_tvalid = 1'b0;
        axis_if.tx_axis_tlast  = 1'b0;
        axis_if.tx_axis_tuser  = 1'b0;
        repeat (3) @(negedge tx_clk0);
        check("reset_txd",   {8'd0, xgmii_txd}, {8'd0, IDLE_W});
        check("reset_txc",   {64'd0, xgmii_txc}, {64'd0, 8'hFF});
        check("reset_tready", {71'd0, axis_if.tx_axis_tready}, 72'd0);
        check("reset_stat_vec", {46'd0, tx_statistics_vector}, 72'd0);
        check("reset_stat_valid", {71'd0, tx_statistics_valid}, 72'd0);

        reset = 1'b0;
        tx_axis_aresetn = 1'b1;
        repeat (5) @(negedge tx_clk0);
        check("disabled_word", {xgmii_txc, xgmii_txd}, {8'hFF, IDLE_W});
        check("disabled_tready", {71'd0, axis_if.tx_axis_tready}, 72'd0);

        tx_configuration_vector = 80'h22;
        tx_dcm_locked = 1'b1;
        repeat (6) @(negedge tx_clk0);
        check("enabled_idle_word", {xgmii_txc, xgmii_txd}, {8'hFF, IDLE_W});
        check("enabled_idle_tready", {71'd0, axis_if.tx_axis_tready}, 72'd0);

        // 60-byte frame, tail FCS shares the last data word
        fill_frame(60, 11);
        fr[0] = 8'h84; fr[1] = 8'h5b; fr[2] = 8'h12; fr[3] = 8'h62; fr[4] = 8'h5b; fr[5] = 8'h9d;
        expect_frame(60, 1'b0);
        send_frame(60, 1'b0, -1);
        drain();

        // 20-byte frame padded to 60
        fill_frame(20, 5);
        expect_frame(20, 1'b0);
        send_frame(20, 1'b0, -1);
        drain();

        // underrun after 3 beats of a 40-byte frame
        fill_frame(40, 77);
        expect_underrun(3);
        send_frame(40, 1'b0, 3);
        drain();

        // tuser marks a 64-byte frame bad
        fill_frame(64, 200);
        expect_frame(64, 1'b1);
        send_frame(64, 1'b1, -1);
        drain();

        // back-to-back frames, minimum gap
        tx_ifg_delay = 8'd0;
        fill_frame(60, 3);
        expect_frame(60, 1'b0);
        send_frame(60, 1'b0, -1);
        fill_frame(61, 9);
        expect_frame(61, 1'b0);
        send_frame(61, 1'b0, -1);
        drain();

        // back-to-back frames, requested 40-byte gap
        tx_ifg_delay = 8'd40;
        fill_frame(63, 21);
        expect_frame(63, 1'b0);
        send_frame(63, 1'b0, -1);
        fill_frame(60, 42);
        expect_frame(60, 1'b0);
        send_frame(60, 1'b0, -1);
        drain();

        check("words_left", {40'd0, 32'(exp_q.size())}, 72'd0);
        check("stats_left", {40'd0, 32'(exp_stat_q.size())}, 72'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
